// File: rtl/knn_uram_banked_mem_pkg.sv
// Shared types and helpers for the banked kNN scratchpad: fill-FSM states,
// bank/row address split and legality checks used at elaboration.
package knn_mem_pkg;
  localparam int unsigned DATA_WIDTH = 256;
  localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;

  typedef enum logic {S_FILL = 1'b0, S_IDLE = 1'b1} fill_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((32'd1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic bit lat_ok(input int unsigned l);
    return (l >= 1) && (l <= 4);
  endfunction

  function automatic bit banks_ok(input int unsigned n);
    return (n >= 1) && (n <= 8) && ((n & (n - 1)) == 0);
  endfunction

  // Low-order interleave: bank from the LSBs, row from what remains.
  function automatic int unsigned bank_sel(input int unsigned addr, input int unsigned nb);
    return addr & (nb - 1);
  endfunction

  function automatic int unsigned row_sel(input int unsigned addr, input int unsigned nb);
    return addr >> clog2(nb);
  endfunction
endpackage

// File: rtl/knn_uram_banked_mem_if.sv
// 1R1W scratchpad bus: writer (distance pipe) and reader (top-K merge) side.
interface knn_uram_banked_mem_if
  import knn_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 11
);
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH/8-1:0] wr_be;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_valid;
  logic                    init_busy;

  modport master (output wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
                  input  rd_data, rd_valid, init_busy);
  modport slave  (input  wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
                  output rd_data, rd_valid, init_busy);
endinterface

// File: rtl/knn_uram_banked_mem_bank.sv
// One URAM bank: byte-enabled synchronous write, single registered read
// (read-before-write on a same-row collision; the top resolves write-first).
module knn_uram_bank
  import knn_mem_pkg::*;
#(
  parameter int unsigned ROWS       = 1024,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned ROW_W      = 10
) (
  input  logic                    clk,
  input  logic                    i_we,
  input  logic [ROW_W-1:0]        i_waddr,
  input  logic [DATA_WIDTH/8-1:0] i_wbe,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic                    i_re,
  input  logic [ROW_W-1:0]        i_raddr,
  output logic [DATA_WIDTH-1:0]   o_rdata
);
  (* ram_style = "ultra" *) logic [DATA_WIDTH-1:0] r_mem [ROWS];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we)
      for (int i = 0; i < DATA_WIDTH/8; i++)
        if (i_wbe[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/knn_uram_banked_mem.sv
// Banked 1R1W scratchpad between the kNN distance pipe and the top-K merge:
// post-reset zero fill, write-first bypass, configurable read latency.
module knn_uram_banked_mem
  import knn_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 256,
  parameter int unsigned DEPTH        = 2048,
  parameter int unsigned NUM_BANKS    = 2,
  parameter int unsigned ADDR_WIDTH   = 11,
  parameter int unsigned READ_LATENCY = 2
) (
  input logic                   clk,
  input logic                   reset,
  knn_uram_banked_mem_if.slave  bus
);
  localparam int unsigned BEW  = DATA_WIDTH / 8;
  localparam int unsigned ROWS = DEPTH / NUM_BANKS;
  localparam int unsigned RW   = (clog2(ROWS) < 1) ? 1 : clog2(ROWS);
  localparam int unsigned BSW  = (clog2(NUM_BANKS) < 1) ? 1 : clog2(NUM_BANKS);

  if (!lat_ok(READ_LATENCY) || !banks_ok(NUM_BANKS) || (DATA_WIDTH % 8 != 0) ||
      (DEPTH % NUM_BANKS != 0) || (ADDR_WIDTH < clog2(DEPTH))) begin : g_bad_cfg
    $error("knn_uram_banked_mem: illegal parameter combination");
  end

  fill_state_e r_state, w_state_nxt;
  logic [RW-1:0] r_fill_cnt, w_fill_cnt_nxt;
  logic w_fill_we, w_busy, w_wr_acc, w_rd_acc, w_rd_in, w_hit;
  logic [BSW-1:0] w_wr_bank, w_rd_bank, r_rd_bank;
  logic [RW-1:0]  w_wr_row, w_rd_row, w_bank_waddr;
  logic [BEW-1:0] w_bank_wbe, r_byp_be;
  logic [DATA_WIDTH-1:0] w_bank_wdata, r_byp_data, w_s1_data;
  logic [NUM_BANKS-1:0] w_bank_we, w_bank_re;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] w_bank_rdata;
  logic r_hit, r_zero;
  logic [READ_LATENCY-1:0] r_vld_pipe;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_FILL;
      r_fill_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fill_cnt <= w_fill_cnt_nxt;
    end
  end

  // Fill writes are gated by reset so a held reset leaves the array alone.
  always_comb begin
    w_state_nxt    = r_state;
    w_fill_cnt_nxt = r_fill_cnt;
    w_fill_we      = 1'b0;
    if (r_state == S_FILL) begin
      w_fill_we      = reset;
      w_fill_cnt_nxt = r_fill_cnt + 1'b1;
      if (r_fill_cnt == RW'(ROWS - 1)) w_state_nxt = S_IDLE;
    end
  end

  assign w_busy        = (r_state == S_FILL);
  assign bus.init_busy = w_busy;

  assign w_wr_bank = BSW'(bank_sel(32'(bus.wr_addr), NUM_BANKS));
  assign w_rd_bank = BSW'(bank_sel(32'(bus.rd_addr), NUM_BANKS));
  assign w_wr_row  = RW'(row_sel(32'(bus.wr_addr), NUM_BANKS));
  assign w_rd_row  = RW'(row_sel(32'(bus.rd_addr), NUM_BANKS));
  assign w_wr_acc  = bus.wr_en && !w_busy && (32'(bus.wr_addr) < DEPTH);
  assign w_rd_acc  = bus.rd_en && !w_busy;
  assign w_rd_in   = (32'(bus.rd_addr) < DEPTH);
  assign w_hit     = w_wr_acc && w_rd_acc && w_rd_in && (bus.wr_addr == bus.rd_addr);

  assign w_bank_waddr = w_fill_we ? r_fill_cnt : w_wr_row;
  assign w_bank_wbe   = w_fill_we ? '1 : bus.wr_be;
  assign w_bank_wdata = w_fill_we ? '0 : bus.wr_data;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign w_bank_we[b] = w_fill_we || (w_wr_acc && (w_wr_bank == BSW'(b)));
    assign w_bank_re[b] = w_rd_acc && w_rd_in && (w_rd_bank == BSW'(b));
    knn_uram_bank #(.ROWS(ROWS), .DATA_WIDTH(DATA_WIDTH), .ROW_W(RW)) u_bank (
      .clk(clk), .i_we(w_bank_we[b]), .i_waddr(w_bank_waddr), .i_wbe(w_bank_wbe),
      .i_wdata(w_bank_wdata), .i_re(w_bank_re[b]), .i_raddr(w_rd_row),
      .o_rdata(w_bank_rdata[b]));
  end

  // Stage-1 side info only moves on an accepted read, so rd_data holds when idle.
  // r_zero resets high to present zero before any bank has been read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hit      <= 1'b0;
      r_zero     <= 1'b1;
      r_rd_bank  <= '0;
      r_byp_be   <= '0;
      r_byp_data <= '0;
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe <= (r_vld_pipe << 1) | READ_LATENCY'(w_rd_acc);
      if (w_rd_acc) begin
        r_hit      <= w_hit;
        r_zero     <= !w_rd_in;
        r_rd_bank  <= w_rd_bank;
        r_byp_be   <= bus.wr_be;
        r_byp_data <= bus.wr_data;
      end
    end
  end

  always_comb begin
    w_s1_data = r_zero ? '0 : w_bank_rdata[r_rd_bank];
    for (int i = 0; i < BEW; i++)
      if (r_hit && r_byp_be[i]) w_s1_data[8*i +: 8] = r_byp_data[8*i +: 8];
  end

  assign bus.rd_valid = r_vld_pipe[READ_LATENCY-1];

  if (READ_LATENCY == 1) begin : g_lat1
    assign bus.rd_data = w_s1_data;
  end else begin : g_latn
    logic [READ_LATENCY-1:1][DATA_WIDTH-1:0] r_dpipe;
    always_ff @(posedge clk) begin
      if (!reset) begin
        r_dpipe <= '0;
      end else begin
        if (r_vld_pipe[0]) r_dpipe[1] <= w_s1_data;
        for (int k = 2; k < READ_LATENCY; k++)
          if (r_vld_pipe[k-1]) r_dpipe[k] <= r_dpipe[k-1];
      end
    end
    assign bus.rd_data = r_dpipe[READ_LATENCY-1];
  end
endmodule

// File: tb/tb_knn_uram_banked_mem.sv
// Scoreboard bench: dut_a at defaults (latency 2), dut_b with DEPTH=1536,
// 4 banks, latency 4. Expected reads are queued at issue, checked on rd_valid.
module tb_knn_uram_banked_mem;
  import knn_mem_pkg::*;
  localparam int DW = 256;
  localparam int AW = 11;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [31:0]   due;
    logic [7:0]    id;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  knn_uram_banked_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ia ();
  knn_uram_banked_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ib ();

  knn_uram_banked_mem dut_a (.clk(clk), .reset(reset), .bus(ia.slave));
  knn_uram_banked_mem #(.DEPTH(1536), .NUM_BANKS(4), .READ_LATENCY(4)) dut_b (
    .clk(clk), .reset(reset), .bus(ib.slave));

  always @(negedge clk) begin
    if (ia.rd_valid) begin
      checks++;
      if (qa.size() == 0) begin
        fails++;
        $display("FAIL a_unexpected_valid got data=%0h, no read outstanding", ia.rd_data);
      end else begin
        ea = qa.pop_front();
        if (ia.rd_data !== ea.d || cyc != int'(ea.due)) begin
          fails++;
          $display("FAIL a_read id=%0d got data=%0h cyc=%0d exp data=%0h cyc=%0d",
                   ea.id, ia.rd_data, cyc, ea.d, ea.due);
        end
      end
    end else if (qa.size() != 0 && cyc > int'(qa[0].due)) begin
      checks++; fails++;
      $display("FAIL a_missing_valid id=%0d cyc=%0d exp cyc=%0d", qa[0].id, cyc, qa[0].due);
      void'(qa.pop_front());
    end
  end

  always @(negedge clk) begin
    if (ib.rd_valid) begin
      checks++;
      if (qb.size() == 0) begin
        fails++;
        $display("FAIL b_unexpected_valid got data=%0h, no read outstanding", ib.rd_data);
      end else begin
        eb = qb.pop_front();
        if (ib.rd_data !== eb.d || cyc != int'(eb.due)) begin
          fails++;
          $display("FAIL b_read id=%0d got data=%0h cyc=%0d exp data=%0h cyc=%0d",
                   eb.id, ib.rd_data, cyc, eb.d, eb.due);
        end
      end
    end else if (qb.size() != 0 && cyc > int'(qb[0].due)) begin
      checks++; fails++;
      $display("FAIL b_missing_valid id=%0d cyc=%0d exp cyc=%0d", qb[0].id, cyc, qb[0].due);
      void'(qb.pop_front());
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ia.wr_en = 1'b0; ia.rd_en = 1'b0;
    ib.wr_en = 1'b0; ib.rd_en = 1'b0;
  endtask

  task automatic wr_a(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] be);
    ia.wr_en = 1'b1; ia.wr_addr = a; ia.wr_data = d; ia.wr_be = be;
  endtask

  task automatic wr_b(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] be);
    ib.wr_en = 1'b1; ib.wr_addr = a; ib.wr_data = d; ib.wr_be = be;
  endtask

  task automatic rd_a(input logic [AW-1:0] a, input logic [DW-1:0] e, input int id);
    exp_t x;
    ia.rd_en = 1'b1; ia.rd_addr = a;
    x.d = e; x.due = 32'(cyc + 2); x.id = 8'(id);
    qa.push_back(x);
  endtask

  task automatic rd_b(input logic [AW-1:0] a, input logic [DW-1:0] e, input int id);
    exp_t x;
    ib.rd_en = 1'b1; ib.rd_addr = a;
    x.d = e; x.due = 32'(cyc + 4); x.id = 8'(id);
    qb.push_back(x);
  endtask

  localparam logic [DW-1:0] ZERO  = '0;
  localparam logic [DW-1:0] ONES  = '1;
  localparam logic [DW-1:0] A5    = {32{8'hA5}};
  localparam logic [DW-1:0] W11   = {32{8'h11}};
  localparam logic [DW-1:0] W22   = {32{8'h22}};
  localparam logic [DW-1:0] MERGE = {{28{8'h11}}, {4{8'h22}}};
  localparam logic [DW-1:0] C3    = {32{8'hC3}};
  localparam logic [DW-1:0] X3C   = {32{8'h3C}};

  int na, nb, k;
  logic [7:0] bv;

  initial begin
    idle();
    ia.wr_addr = '0; ia.wr_be = '0; ia.wr_data = '0; ia.rd_addr = '0;
    ib.wr_addr = '0; ib.wr_be = '0; ib.wr_data = '0; ib.rd_addr = '0;
    repeat (3) step();
    chk("reset_rd_valid_a", DW'(ia.rd_valid), ZERO);
    chk("reset_rd_data_a", ia.rd_data, ZERO);
    chk("reset_rd_data_b", ib.rd_data, ZERO);
    chk("reset_busy_a", DW'(ia.init_busy), DW'(1));

    // First fill, interrupted by reset at fill cycle 500.
    reset = 1'b1;
    repeat (500) step();
    reset = 1'b0;
    step(); step();
    chk("midfill_reset_busy_b", DW'(ib.init_busy), DW'(1));
    reset = 1'b1;

    na = 0; nb = 0; k = 0;
    while ((ia.init_busy || ib.init_busy) && k < 3000) begin
      if (ia.init_busy) na++;
      if (ib.init_busy) nb++;
      if (k == 300) begin
        wr_a(11'h020, ONES, '1); rd_a(11'h020, ZERO, 0); void'(qa.pop_back());
        wr_b(11'h020, ONES, '1); rd_b(11'h020, ZERO, 0); void'(qb.pop_back());
      end else idle();
      step();
      k++;
    end
    idle();
    chk("fill_cycles_a", DW'(na), DW'(1024));
    chk("fill_cycles_b", DW'(nb), DW'(384));

    rd_a(11'h7FF, ZERO, 1); step(); idle();
    rd_a(11'h020, ZERO, 2); rd_b(11'h020, ZERO, 3); step(); idle();

    wr_a(11'h005, A5, '1); step(); idle();
    rd_a(11'h005, A5, 4); step(); idle();

    wr_a(11'h010, W11, '1); step();
    wr_a(11'h010, W22, 32'h0000_000F); rd_a(11'h010, MERGE, 5); step(); idle();
    rd_a(11'h010, MERGE, 6); step(); idle();

    wr_a(11'h030, C3, '1); rd_a(11'h005, A5, 7); step();
    wr_a(11'h031, X3C, '1); rd_a(11'h030, C3, 8); step(); idle();
    rd_a(11'h031, X3C, 9); step(); idle();

    wr_a(11'h005, ONES, '0); step(); idle();
    rd_a(11'h005, A5, 10); step(); idle();

    for (int i = 0; i < 16; i++) begin
      bv = 8'h40 + 8'(i);
      wr_b(AW'(i), {32{bv}}, '1);
      if (i == 1) begin
        #1;
        chk("bank_we_addr1_b", DW'(dut_b.w_bank_we), DW'(4'b0010));
      end
      step();
    end
    idle();
    for (int i = 0; i < 16; i++) begin
      bv = 8'h40 + 8'(i);
      rd_b(AW'(i), {32{bv}}, 16 + i);
      if (i == 1) begin
        #1;
        chk("bank_re_addr1_b", DW'(dut_b.w_bank_re), DW'(4'b0010));
      end
      step();
    end
    idle();

    wr_b(11'h600, ONES, '1);
    #1;
    chk("oor_write_no_bank_b", DW'(dut_b.w_bank_we), ZERO);
    step(); idle();
    rd_b(11'h600, ZERO, 40); step(); idle();
    rd_b(11'h5FF, ZERO, 41); step(); idle();

    repeat (8) step();
    chk("drain_queue_a", DW'(qa.size()), ZERO);
    chk("drain_queue_b", DW'(qb.size()), ZERO);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
